// File: rtl/gate_exhaustive_checker.sv
// Clocked exhaustive sequencer/checker for 3-input gates: drives {a,b,c} through 0..7,
// samples d after a settle window and compares it against TRUTH_TABLE.
module gate_exhaustive_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  TRUTH_TABLE   = 8'h7F
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       d,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_vec
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] abc_q, abc_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] err_q, err_d;
  logic [7:0] fail_q, fail_d;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    abc_d   = abc_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fail_d  = fail_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          vec_d   = '0;
          abc_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          fail_d  = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      SAMPLE: begin
        if (d != TRUTH_TABLE[vec_q]) begin
          err_d         = err_q + 4'd1;
          fail_d[vec_q] = 1'b1;
        end
        if (vec_q != 3'd7) begin
          vec_d   = vec_q + 3'd1;
          abc_d   = vec_q + 3'd1;
          state_d = SETTLE;
        end else begin
          abc_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // err_d already includes this cycle's mismatch
          pass_d  = (err_d == 4'd0);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      abc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      abc_q   <= abc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign {a, b, c} = abc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_exhaustive_checker.sv
// Bench for gate_exhaustive_checker: a SETTLE_CYCLES=2 instance with selectable gate models,
// and a SETTLE_CYCLES=1 instance permanently fed by a registered NAND.
module tb_gate_exhaustive_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start;
  logic       a1, b1, c1, d1, busy1, done1, pass1;
  logic [3:0] err1;
  logic [7:0] fail1;
  logic       a2, b2, c2, d2, busy2, done2, pass2;
  logic [3:0] err2;
  logic [7:0] fail2;
  logic       dreg1, dreg2;
  int         mode;

  int total = 0;
  int bad   = 0;

  // 0 nand, 1 stuck-at-1, 2 stuck-at-0, 3 registered nand, 4 two-input nand (a,b)
  always @(posedge clk) begin
    dreg1 <= ~(a1 & b1 & c1);
    dreg2 <= ~(a2 & b2 & c2);
  end

  always_comb begin
    case (mode)
      0:       d1 = ~(a1 & b1 & c1);
      1:       d1 = 1'b1;
      2:       d1 = 1'b0;
      3:       d1 = dreg1;
      default: d1 = ~(a1 & b1);
    endcase
  end

  assign d2 = dreg2;

  gate_exhaustive_checker #(.SETTLE_CYCLES(2), .TRUTH_TABLE(8'h7F)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a1), .b(b1), .c(c1), .d(d1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fail1)
  );

  gate_exhaustive_checker #(.SETTLE_CYCLES(1), .TRUTH_TABLE(8'h7F)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a2), .b(b2), .c(c2), .d(d2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_vec(fail2)
  );

  typedef struct {
    int         mode;
    int         err;
    logic [7:0] fail;
    logic       pass;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start, then count cycles after the accept edge until each instance reports done.
  task automatic sweep(input bit track, output int lat1, output int lat2);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat1 = -1;
    lat2 = -1;
    for (int k = 0; k < 60; k++) begin
      if (lat1 < 0 && done1) lat1 = k;
      if (lat2 < 0 && done2) lat2 = k;
      if (lat1 >= 0 && lat2 >= 0) break;
      if (track && k < 24) begin
        chk("sweep_abc", int'({a1, b1, c1}), k / 3);
        chk("sweep_busy", int'(busy1), 1);
      end
      tick();
    end
  endtask

  task automatic wait_done1();
    for (int i = 0; i < 40 && !done1; i++) tick();
    chk("wait_done1", int'(done1), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int l1, l2;
    vecs[0] = '{0, 0, 8'h00, 1'b1};
    vecs[1] = '{1, 1, 8'h80, 1'b0};
    vecs[2] = '{2, 7, 8'h7F, 1'b0};
    vecs[3] = '{3, 0, 8'h00, 1'b1};
    vecs[4] = '{4, 1, 8'h40, 1'b0};

    mode  = 0;
    start = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_abc", int'({a1, b1, c1}), 0);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_done", int'(done1), 0);
    chk("rst_pass", int'(pass1), 0);
    chk("rst_err", int'(err1), 0);
    chk("rst_fail", int'(fail1), 0);
    chk("rst_busy2", int'(busy2), 0);
    tick(); tick(); tick();
    chk("idle_busy", int'(busy1), 0);
    chk("idle_done", int'(done1), 0);
    chk("idle_abc", int'({a1, b1, c1}), 0);

    foreach (vecs[i]) begin
      mode = vecs[i].mode;
      sweep(i == 0, l1, l2);
      chk("tbl_latency", l1, 24);
      chk("tbl_err", int'(err1), vecs[i].err);
      chk("tbl_fail", int'(fail1), int'(vecs[i].fail));
      chk("tbl_pass", int'(pass1), int'(vecs[i].pass));
      chk("tbl_busy", int'(busy1), 0);
      chk("tbl_abc", int'({a1, b1, c1}), 0);
      chk("reg1_latency", l2, 16);
      chk("reg1_pass", int'(pass2), 1);
      chk("reg1_err", int'(err2), 0);
    end

    // start held high: no restart while busy, restart once DONE is reached
    mode  = 0;
    start = 1'b1;
    tick();
    for (int k = 1; k < 24; k++) begin
      tick();
      chk("hold_busy", int'(busy1), 1);
      chk("hold_abc", int'({a1, b1, c1}), k / 3);
      chk("hold_done", int'(done1), 0);
    end
    tick();
    chk("hold_done_end", int'(done1), 1);
    chk("hold_pass_end", int'(pass1), 1);
    tick();
    chk("hold_restart_done", int'(done1), 0);
    chk("hold_restart_busy", int'(busy1), 1);
    start = 1'b0;
    wait_done1();
    chk("hold_final_pass", int'(pass1), 1);

    // restart from DONE clears previous results on the accept edge
    mode = 2;
    sweep(1'b0, l1, l2);
    chk("pre_restart_err", int'(err1), 7);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_err", int'(err1), 0);
    chk("restart_fail", int'(fail1), 0);
    chk("restart_done", int'(done1), 0);
    chk("restart_pass", int'(pass1), 0);
    chk("restart_busy", int'(busy1), 1);
    wait_done1();
    chk("restart_final_err", int'(err1), 7);

    // reset mid-sweep at vec = 3
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 30 && {a1, b1, c1} != 3'd3; i++) tick();
    chk("mid_abc", int'({a1, b1, c1}), 3);
    chk("mid_fail", int'(fail1), 8'h07);
    rst_n = 1'b0;
    tick();
    chk("midrst_abc", int'({a1, b1, c1}), 0);
    chk("midrst_busy", int'(busy1), 0);
    chk("midrst_done", int'(done1), 0);
    chk("midrst_pass", int'(pass1), 0);
    chk("midrst_err", int'(err1), 0);
    chk("midrst_fail", int'(fail1), 0);
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("midrst_idle_busy", int'(busy1), 0);
    chk("midrst_idle_abc", int'({a1, b1, c1}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
